// File: rtl/cam_rgb565_capture_if.sv
// Camera byte bus in, RGB565 pixel stream and frame status out.
// The sensor/bench side drives the camera pins; the capture block drives the rest.
interface cam_rgb565_capture_if;
    logic        vsync;
    logic        href;
    logic [7:0]  cam_data;
    logic [15:0] PIXEL;
    logic        pixel_valid;
    logic [9:0]  x_count;
    logic [9:0]  y_count;
    logic        frame_done;
    logic        frame_err;
    logic        HDMI_EN;

    modport master (
        output vsync, href, cam_data,
        input  PIXEL, pixel_valid, x_count, y_count,
        input  frame_done, frame_err, HDMI_EN
    );

    modport slave (
        input  vsync, href, cam_data,
        output PIXEL, pixel_valid, x_count, y_count,
        output frame_done, frame_err, HDMI_EN
    );
endinterface

// File: rtl/cam_rgb565_capture.sv
// Camera capture front end: frames vsync/href, pairs bytes into RGB565,
// tracks pixel position, flags frame health and raises the display start enable.
module cam_rgb565_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture_en,
    cam_rgb565_capture_if.slave   bus
);

    localparam logic [9:0] H_MAX     = 10'(H_ACTIVE);
    localparam logic [9:0] V_MAX     = 10'(V_ACTIVE);
    localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SKIP,
        CAPTURE
    } state_t;

    state_t     state;
    logic       vs_r;
    logic       href_r;
    logic [7:0] data_r;
    logic       vs_act_d;
    logic       line_d;
    logic [7:0] skip_cnt;
    logic       phase;
    logic [7:0] hi_byte;
    logic [9:0] x_int;
    logic [9:0] y_int;
    logic       err_lat;

    logic       vs_act;
    logic       vs_fall;
    logic       vs_rise;
    logic       line_act;
    logic       line_rise;
    logic       line_fall;
    logic       in_cap;
    logic [9:0] x_eff;
    logic       pix_ok;
    logic       pix_drop;
    logic       fall_bad;
    logic [9:0] y_inc;
    logic [9:0] y_after;
    logic       err_after;
    logic       frame_ok;

    // Register the camera pins once on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_r   <= 1'b0;
            href_r <= 1'b0;
            data_r <= 8'h00;
        end else begin
            vs_r   <= bus.vsync;
            href_r <= bus.href;
            data_r <= bus.cam_data;
        end
    end

    // Edge detection and per-cycle line/frame bookkeeping decisions.
    always_comb begin
        vs_act    = (vs_r == VSYNC_POL);
        vs_fall   = vs_act_d & ~vs_act;
        vs_rise   = vs_act & ~vs_act_d;
        line_act  = href_r & ~vs_act;
        line_rise = line_act & ~line_d;
        line_fall = line_d & ~line_act;
        in_cap    = (state == CAPTURE);
        x_eff     = line_rise ? 10'd0 : x_int;
        pix_ok    = in_cap & line_act & phase
                  & (x_eff < H_MAX) & (y_int < V_MAX);
        pix_drop  = in_cap & line_act & phase & ~pix_ok;
        fall_bad  = in_cap & line_fall & (phase | (x_int < H_MAX));
        y_inc     = (y_int < V_MAX) ? y_int + 10'd1 : y_int;
        y_after   = (in_cap & line_fall) ? y_inc : y_int;
        err_after = err_lat | fall_bad | pix_drop;
        frame_ok  = (y_after == V_MAX) & ~err_after;
    end

    // Capture FSM with registered pixel, position and frame status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            vs_act_d        <= 1'b0;
            line_d          <= 1'b0;
            skip_cnt        <= 8'd0;
            phase           <= 1'b0;
            hi_byte         <= 8'h00;
            x_int           <= 10'd0;
            y_int           <= 10'd0;
            err_lat         <= 1'b0;
            bus.PIXEL       <= 16'h0000;
            bus.pixel_valid <= 1'b0;
            bus.x_count     <= 10'd0;
            bus.y_count     <= 10'd0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.HDMI_EN     <= 1'b0;
        end else begin
            vs_act_d        <= vs_act;
            line_d          <= line_act;
            bus.pixel_valid <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (capture_en) state <= SYNC;
                end
                SYNC: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        skip_cnt <= 8'd0;
                        state    <= (SKIP_FRAMES > 0) ? SKIP : CAPTURE;
                    end
                end
                SKIP: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        if (skip_cnt == SKIP_LAST) state <= CAPTURE;
                        else skip_cnt <= skip_cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    if (line_rise) x_int <= 10'd0;
                    if (line_act) begin
                        if (!phase) begin
                            hi_byte <= data_r;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (pix_ok) begin
                                bus.PIXEL       <= {hi_byte, data_r};
                                bus.pixel_valid <= 1'b1;
                                bus.x_count     <= x_eff;
                                bus.y_count     <= y_int;
                                bus.HDMI_EN     <= 1'b1;
                                x_int           <= x_eff + 10'd1;
                            end
                        end
                    end
                    if (line_fall) begin
                        phase <= 1'b0;
                        y_int <= y_inc;
                    end
                    err_lat <= err_after;
                    if (vs_rise) begin
                        bus.frame_done <= frame_ok;
                        bus.frame_err  <= ~frame_ok;
                        y_int          <= 10'd0;
                        err_lat        <= 1'b0;
                        if (!capture_en) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: directed frame shapes plus random frames,
// checked against a frame-level model of expected pixels and frame status.
module tb_cam_rgb565_capture;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int SKIP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_en = 1'b0;

    cam_rgb565_capture_if bus ();

    cam_rgb565_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .SKIP_FRAMES(SKIP),
        .VSYNC_POL  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_en(capture_en),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        int          x;
        int          y;
        int          c;
        logic        en;
    } pix_t;

    pix_t obs_q[$];
    pix_t exp_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lb[8];
    bit   directed = 1'b0;
    bit   active = 1'b0;
    int   skip_left = 0;
    int   exp_done = 0;
    int   exp_err = 0;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Record everything the DUT emits, away from the active edge.
    always @(negedge clk) begin
        if (bus.pixel_valid)
            obs_q.push_back('{bus.PIXEL, int'(bus.x_count),
                              int'(bus.y_count), cyc, bus.HDMI_EN});
        if (bus.frame_done) done_cnt++;
        if (bus.frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix"}, bus.PIXEL, 0);
        chk({tag, "_pv"}, bus.pixel_valid, 0);
        chk({tag, "_x"}, bus.x_count, 0);
        chk({tag, "_y"}, bus.y_count, 0);
        chk({tag, "_done"}, bus.frame_done, 0);
        chk({tag, "_err"}, bus.frame_err, 0);
        chk({tag, "_hdmi"}, bus.HDMI_EN, 0);
    endtask

    // One camera frame: vsync fall, lines of lb[] bytes, vsync rise.
    // The model predicts pixels from byte pairs and the frame verdict
    // from line count and line lengths.
    task automatic run_frame(input int nl, input int drop_line,
                             input int rst_line);
        bit         cap;
        bit         good;
        logic [7:0] b;
        logic [7:0] hi;
        cap  = active && (skip_left == 0);
        if (active && skip_left > 0) skip_left--;
        good = (nl == V);
        hi   = 8'h00;
        bus.vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) capture_en = 1'b0;
            if (lb[l] != 2 * H) good = 1'b0;
            for (int k = 0; k < lb[l]; k++) begin
                b = directed ? 8'(8'hA1 + 8'h11 * k) : 8'($urandom);
                bus.href     = 1'b1;
                bus.cam_data = b;
                if (k % 2 == 0) hi = b;
                else if (cap && l < V && k / 2 < H)
                    exp_q.push_back('{{hi, b}, k / 2, l, cyc + 2, 1'b1});
                tick();
                if (l == rst_line && k == 3) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    chk_zero("rst_mid");
                    obs_q.delete();
                    exp_q.delete();
                    done_cnt  = 0;
                    err_cnt   = 0;
                    cap       = 1'b0;
                    skip_left = SKIP;
                end
            end
            bus.href = 1'b0;
            repeat (3) tick();
        end
        bus.vsync = 1'b1;
        repeat (6) tick();
        exp_done = (cap && good) ? 1 : 0;
        exp_err  = (cap && !good) ? 1 : 0;
        if (cap && !capture_en) active = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        pix_t o;
        pix_t e;
        chk({tag, "_npix"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_pix"}, o.pix, e.pix);
            chk({tag, "_x"}, o.x, e.x);
            chk({tag, "_y"}, o.y, e.y);
            chk({tag, "_lat"}, o.c, e.c);
            chk({tag, "_hdmi"}, o.en, e.en);
        end
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_ferr"}, err_cnt, exp_err);
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic set_lines(input int a, input int b, input int c);
        lb[0] = a;
        lb[1] = b;
        lb[2] = c;
    endtask

    initial begin
        bus.vsync    = 1'b1;
        bus.href     = 1'b0;
        bus.cam_data = 8'h00;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        capture_en = 1'b1;
        active     = 1'b1;
        skip_left  = SKIP;
        tick();
        set_lines(8, 8, 8);
        run_frame(2, -1, -1);
        check_frame("skip1");
        run_frame(2, -1, -1);
        check_frame("skip2");
        chk("hdmi_pre", bus.HDMI_EN, 0);

        directed = 1'b1;
        run_frame(2, -1, -1);
        chk("first_pix", obs_q.size() > 0 ? 32'(obs_q[0].pix) : 'x,
            16'hA1B2);
        chk("second_pix", obs_q.size() > 1 ? 32'(obs_q[1].pix) : 'x,
            16'hC3D4);
        check_frame("nominal");
        directed = 1'b0;
        chk("hdmi_on", bus.HDMI_EN, 1);

        set_lines(8, 6, 8);
        run_frame(2, -1, -1);
        check_frame("short_line");
        set_lines(9, 8, 8);
        run_frame(2, -1, -1);
        check_frame("odd_byte");
        set_lines(20, 8, 8);
        run_frame(2, -1, -1);
        check_frame("long_line");
        set_lines(8, 8, 8);
        run_frame(1, -1, -1);
        check_frame("short_frame");
        run_frame(3, -1, -1);
        check_frame("extra_line");

        repeat (8) begin
            for (int i = 0; i < 3; i++)
                lb[i] = ($urandom_range(0, 2) == 0)
                      ? int'($urandom_range(5, 11)) : 8;
            run_frame(int'($urandom_range(1, 3)), -1, -1);
            check_frame("random");
        end

        set_lines(8, 8, 8);
        run_frame(2, 1, -1);
        check_frame("disable");
        run_frame(2, -1, -1);
        check_frame("idle");
        chk("hdmi_sticky", bus.HDMI_EN, 1);

        capture_en = 1'b1;
        active     = 1'b1;
        skip_left  = SKIP;
        tick();
        run_frame(2, -1, -1);
        check_frame("reskip1");
        run_frame(2, -1, -1);
        check_frame("reskip2");
        run_frame(2, -1, 0);
        check_frame("rst_frame");
        run_frame(2, -1, -1);
        check_frame("post_rst1");
        run_frame(2, -1, -1);
        check_frame("post_rst2");
        chk("hdmi_post_rst", bus.HDMI_EN, 0);
        run_frame(2, -1, -1);
        check_frame("recover");
        chk("hdmi_recover", bus.HDMI_EN, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
